// File: rtl/dcnn_pkg.sv
// Shared definitions for the window loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the K-size encoding, the tap limit, the loader state enum and the
// default register-index width, plus a helper giving the last row/column
// index for a given K-size code.
package dcnn_pkg;

    // K_SIZE encoding
    localparam logic K3 = 1'b0;
    localparam logic K5 = 1'b1;

    localparam int MAX_TAPS      = 25;
    localparam int SEL_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        LAST = 2'd2
    } state_t;

    // Highest row/column index (K-1) for a K-size code.
    function automatic logic [2:0] k_last(input logic k_size);
        return (k_size == K5) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Window address generator: walks a KxK window row by row.
// Latency: address/tap update one cycle after load_i or adv_i.
// Backpressure: none; advances only when adv_i is asserted.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   load_i          latch k_size_i/base_i/stride_i and point at tap (0,0)
//   adv_i           step to the next tap (column first, then row)
//   k_size_i        0 = 3x3, 1 = 5x5
//   base_i          address of tap (0,0)
//   stride_i        address distance between window rows
//   addr_o          registered address of the current tap
//   tap_o           index r*K + c of the current tap
//   last_o          current tap is (K-1,K-1)
module window_addr_gen
    import dcnn_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int SEL_W  = SEL_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic              k_size_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [SEL_W-1:0]  tap_o,
    output logic              last_o
);

    logic              k5_q,       k5_d;
    logic [ADDR_W-1:0] stride_q,   stride_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [2:0]        col_q,      col_d;
    logic [2:0]        row_q,      row_d;
    logic [SEL_W-1:0]  tap_q,      tap_d;

    logic col_wrap;
    logic row_wrap;

    assign col_wrap = (col_q == k_last(k5_q));
    assign row_wrap = (row_q == k_last(k5_q));
    assign last_o   = col_wrap && row_wrap;
    assign addr_o   = addr_q;
    assign tap_o    = tap_q;

    // Row base is accumulated by repeated addition of the stride, so no
    // multiplier is needed; all additions wrap modulo 2^ADDR_W.
    always_comb begin
        k5_d       = k5_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        col_d      = col_q;
        row_d      = row_q;
        tap_d      = tap_q;
        if (load_i) begin
            k5_d       = k_size_i;
            stride_d   = stride_i;
            row_base_d = base_i;
            addr_d     = base_i;
            col_d      = 3'd0;
            row_d      = 3'd0;
            tap_d      = '0;
        end else if (adv_i) begin
            tap_d = tap_q + SEL_W'(1);
            if (col_wrap) begin
                col_d      = 3'd0;
                row_d      = row_q + 3'd1;
                row_base_d = row_base_q + stride_q;
                addr_d     = row_base_q + stride_q;
            end else begin
                col_d  = col_q + 3'd1;
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            k5_q       <= K3;
            stride_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            col_q      <= 3'd0;
            row_q      <= 3'd0;
            tap_q      <= '0;
        end else begin
            k5_q       <= k5_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            col_q      <= col_d;
            row_q      <= row_d;
            tap_q      <= tap_d;
        end
    end

endmodule

// File: rtl/window_loader.sv
// Window loader: reads a KxK window from RAM and writes one bank register per tap.
// Latency: first read 1 cycle after START, first write 2 cycles after, DONE with last write.
// Backpressure: none; START while busy is dropped, not queued.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   START                    one-cycle request, sampled only when idle
//   K_SIZE                   0 = 3x3, 1 = 5x5 (latched on START)
//   BASE_ADDR, ROW_STRIDE    window origin and row pitch (latched on START)
//   ABORT                    only with WINDOW_LOADER_ABORT_EN: cancel the load
//   MEM_RD, MEM_ADDR         registered RAM read request/address
//   MEM_DATA                 RAM read data, valid the cycle after MEM_RD
//   WR_EN, WR_SEL, WR_DATA   register-bank write strobe, index, data
//   BUSY, DONE               load in progress / final-write pulse
//
// Optional feature macro: WINDOW_LOADER_ABORT_EN adds the ABORT input.
module window_loader
    import dcnn_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int SEL_W  = SEL_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              K_SIZE,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] ROW_STRIDE,
`ifdef WINDOW_LOADER_ABORT_EN
    input  logic              ABORT,
`endif
    output logic              MEM_RD,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              WR_EN,
    output logic [SEL_W-1:0]  WR_SEL,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY,
    output logic              DONE
);

    state_t           state_q;
    logic             mem_rd_q;
    logic             wr_en_q;
    logic [SEL_W-1:0] wr_sel_q;
    logic             busy_q;
    logic             done_q;

    logic             ag_load;
    logic             ag_adv;
    logic [SEL_W-1:0] ag_tap;
    logic             ag_last;

    assign ag_load = (state_q == IDLE) && START;
    assign ag_adv  = (state_q == READ) && !ag_last;

    window_addr_gen #(
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W)
    ) u_addr_gen (
        .CLK      (CLK),
        .RST      (RST),
        .load_i   (ag_load),
        .adv_i    (ag_adv),
        .k_size_i (K_SIZE),
        .base_i   (BASE_ADDR),
        .stride_i (ROW_STRIDE),
        .addr_o   (MEM_ADDR),
        .tap_o    (ag_tap),
        .last_o   (ag_last)
    );

    assign MEM_RD  = mem_rd_q;
    assign WR_EN   = wr_en_q;
    assign WR_SEL  = wr_sel_q;
    assign WR_DATA = MEM_DATA;
    assign BUSY    = busy_q;
    assign DONE    = done_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            mem_rd_q <= 1'b0;
            wr_en_q  <= 1'b0;
            wr_sel_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Write pipeline: each read turns into a write one cycle later,
            // when its data is on MEM_DATA.
            wr_en_q <= mem_rd_q;
            if (mem_rd_q) begin
                wr_sel_q <= ag_tap;
            end

            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        state_q  <= READ;
                        mem_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                READ: begin
                    // The read for the last tap is on the bus this cycle;
                    // the next cycle carries only its write.
                    if (ag_last) begin
                        state_q  <= LAST;
                        mem_rd_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                LAST: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    mem_rd_q <= 1'b0;
                    done_q   <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase

`ifdef WINDOW_LOADER_ABORT_EN
            // Abort overrides everything above, including the write for the
            // read already in flight and any pending DONE.
            if (ABORT && busy_q) begin
                state_q  <= IDLE;
                mem_rd_q <= 1'b0;
                wr_en_q  <= 1'b0;
                done_q   <= 1'b0;
                busy_q   <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_window_loader.sv
module tb_window_loader;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        K_SIZE;
    logic [15:0] BASE_ADDR;
    logic [15:0] ROW_STRIDE;
`ifdef WINDOW_LOADER_ABORT_EN
    logic        ABORT;
`endif
    logic        MEM_RD;
    logic [15:0] MEM_ADDR;
    logic [31:0] MEM_DATA;
    logic        WR_EN;
    logic [4:0]  WR_SEL;
    logic [31:0] WR_DATA;
    logic        BUSY;
    logic        DONE;

    int n_chk = 0;
    int n_err = 0;
    bit ram_ident = 1'b1;

    window_loader dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .K_SIZE     (K_SIZE),
        .BASE_ADDR  (BASE_ADDR),
        .ROW_STRIDE (ROW_STRIDE),
`ifdef WINDOW_LOADER_ABORT_EN
        .ABORT      (ABORT),
`endif
        .MEM_RD     (MEM_RD),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .WR_EN      (WR_EN),
        .WR_SEL     (WR_SEL),
        .WR_DATA    (WR_DATA),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM contents: identity (RAM[a] = a) or a scrambled word per address.
    function automatic logic [31:0] ram_f(input logic [15:0] a);
        if (ram_ident) return {16'h0000, a};
        return {a ^ 16'hC3A5, a};
    endfunction

    // Synchronous-read RAM: data valid the cycle after MEM_RD.
    always @(posedge CLK) begin
        if (MEM_RD) MEM_DATA <= ram_f(MEM_ADDR);
    end

    // Reference: address of tap idx = base + r*stride + c, modulo 2^16.
    function automatic logic [15:0] addr_of(input logic [15:0] base, input logic [15:0] stride,
                                            input int k, input int idx);
        int r;
        int c;
        r = idx / k;
        c = idx % k;
        return 16'(int'(base) + r * int'(stride) + c);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_rd"},   32'(MEM_RD),   32'd0);
        chk({tag, "_mem_addr"}, 32'(MEM_ADDR), 32'd0);
        chk({tag, "_wr_en"},    32'(WR_EN),    32'd0);
        chk({tag, "_wr_sel"},   32'(WR_SEL),   32'd0);
        chk({tag, "_busy"},     32'(BUSY),     32'd0);
        chk({tag, "_done"},     32'(DONE),     32'd0);
    endtask

    // Starts a load at the next edge (called at a negedge) and checks every
    // cycle of it against the reference timeline. rst_at/abort_at (>0) cut
    // the load short after checking that cycle.
    task automatic run_load(input logic k5, input logic [15:0] base, input logic [15:0] stride,
                            input bit hold, input int rst_at, input int abort_at);
        int k;
        int t;
        int wr_seen;
        k = k5 ? 5 : 3;
        t = k * k;
        wr_seen = 0;
        START      = 1'b1;
        K_SIZE     = k5;
        BASE_ADDR  = base;
        ROW_STRIDE = stride;
        @(posedge CLK);
        #1;
        if (!hold) START = 1'b0;
        for (int j = 1; j <= t + 2; j++) begin
            @(negedge CLK);
            chk("mem_rd", 32'(MEM_RD), 32'(j <= t));
            if (j <= t) chk("mem_addr", 32'(MEM_ADDR), 32'(addr_of(base, stride, k, j - 1)));
            chk("wr_en", 32'(WR_EN), 32'(j >= 2 && j <= t + 1));
            if (WR_EN) wr_seen++;
            if (j >= 2 && j <= t + 1) begin
                chk("wr_sel",  32'(WR_SEL), 32'(j - 2));
                chk("wr_data", WR_DATA, ram_f(addr_of(base, stride, k, j - 2)));
            end
            chk("done", 32'(DONE), 32'(j == t + 1));
            chk("busy", 32'(BUSY), 32'(j <= t + 1));
            if (j == rst_at) begin
                START = 1'b0;
                RST = 1'b1;
                #1;
                chk_idle_outputs("rst_async");
                @(negedge CLK);
                chk("rst_hold_done", 32'(DONE), 32'd0);
                chk("rst_hold_busy", 32'(BUSY), 32'd0);
                RST = 1'b0;
                return;
            end
`ifdef WINDOW_LOADER_ABORT_EN
            if (j == abort_at) begin
                START = 1'b0;
                ABORT = 1'b1;
                @(negedge CLK);
                ABORT = 1'b0;
                chk("abort_busy",   32'(BUSY),   32'd0);
                chk("abort_wr_en",  32'(WR_EN),  32'd0);
                chk("abort_done",   32'(DONE),   32'd0);
                chk("abort_mem_rd", 32'(MEM_RD), 32'd0);
                chk("abort_writes", 32'(wr_seen), 32'(j - 1));
                return;
            end
`endif
            // Latched parameters must be used; START during busy is ignored.
            if (!hold) begin
                K_SIZE     = 1'($urandom);
                BASE_ADDR  = 16'($urandom);
                ROW_STRIDE = 16'($urandom);
                START      = (j <= t + 1) ? 1'($urandom) : 1'b0;
            end
        end
        chk("load_writes", 32'(wr_seen), 32'(t));
    endtask

    initial begin
        RST        = 1'b1;
        START      = 1'b0;
        K_SIZE     = 1'b0;
        BASE_ADDR  = '0;
        ROW_STRIDE = '0;
`ifdef WINDOW_LOADER_ABORT_EN
        ABORT      = 1'b0;
`endif
        repeat (2) @(negedge CLK);
        chk_idle_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);

        // Directed loads with RAM[a] = a.
        ram_ident = 1'b1;
        run_load(1'b0, 16'h0100, 16'h0020, 1'b0, 0, 0);
        run_load(1'b1, 16'h0000, 16'h0040, 1'b0, 0, 0);
        run_load(1'b0, 16'hFFFE, 16'h0001, 1'b0, 0, 0);
        // START held high: one load, next one starts right after the gap.
        run_load(1'b0, 16'h0200, 16'h0010, 1'b1, 0, 0);
        run_load(1'b0, 16'h0200, 16'h0010, 1'b0, 0, 0);
        // Reset at the fourth write of a 5x5 load, then a full load.
        run_load(1'b1, 16'h0300, 16'h0008, 1'b0, 5, 0);
        run_load(1'b1, 16'h0300, 16'h0008, 1'b0, 0, 0);
`ifdef WINDOW_LOADER_ABORT_EN
        // Abort during the sixth read, then an immediate new load.
        run_load(1'b0, 16'h0050, 16'h0010, 1'b0, 0, 6);
        run_load(1'b0, 16'h0060, 16'h0010, 1'b0, 0, 0);
        // ABORT in idle has no effect; ABORT with START in idle: START wins.
        ABORT = 1'b1;
        @(negedge CLK);
        chk("abort_idle_busy", 32'(BUSY), 32'd0);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        ABORT = 1'b0;
        chk("abort_start_busy", 32'(BUSY), 32'd1);
        chk("abort_start_rd",   32'(MEM_RD), 32'd1);
        repeat (30) @(negedge CLK);
`endif

        // Randomized loads with a scrambled RAM image.
        ram_ident = 1'b0;
        for (int i = 0; i < 30; i++) begin
            logic        rk;
            logic [15:0] rb;
            logic [15:0] rs;
            rk = 1'($urandom);
            rb = 16'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            run_load(rk, rb, rs, 1'b0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/window_loader.md
Name: window_loader

Overview:
- Upstream feeder for the accelerator's 32-bit register bank (window/filter registers).
- On START, walks a KxK window in on-chip RAM row by row and emits one write strobe per tap.
- Each write carries the register index and the data word, so the bank loads one register per cycle.
- Sits between the image/filter RAM read port and the register bank enables.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DATA_W, 32, data word width; matches the register bank.
- SEL_W, 5, register index width; must hold 0..24.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- K_SIZE  in  1  window size: 0 = 3x3, 1 = 5x5; latched on START.
- BASE_ADDR  in  ADDR_W  address of tap (0,0); latched on START.
- ROW_STRIDE  in  ADDR_W  address distance between window rows; latched on START.
- MEM_RD  out  1  registered RAM read request.
- MEM_ADDR  out  ADDR_W  registered RAM read address.
- MEM_DATA  in  DATA_W  RAM read data; valid the cycle after MEM_RD.
- WR_EN  out  1  register-bank write strobe.
- WR_SEL  out  SEL_W  target register index = r*K + c.
- WR_DATA  out  DATA_W  combinational pass-through of MEM_DATA.
- BUSY  out  1  high while a load is in progress.
- DONE  out  1  one-cycle pulse coincident with the final write.

Behaviour:
- Reset values: MEM_RD=0, MEM_ADDR=0, WR_EN=0, WR_SEL=0, BUSY=0, DONE=0, state=IDLE, counters=0. WR_DATA follows MEM_DATA and has no reset value.
- K = 3 when K_SIZE=0, K = 5 when K_SIZE=1. Taps = K*K (9 or 25).
- States:
  - IDLE: START=1 latches K_SIZE, BASE_ADDR and ROW_STRIDE, then goes to READ.
  - READ: one read per cycle. Column c runs 0..K-1, row r runs 0..K-1. MEM_ADDR = row_base + c, where row_base starts at BASE_ADDR and adds ROW_STRIDE at each row wrap. No multiplier.
  - After the read for (K-1,K-1) is issued: go to LAST.
  - LAST: one cycle carrying the final write; DONE=1; next state IDLE.
- Timing: START at edge n.
  - MEM_RD is high in cycles n+1 .. n+K².
  - WR_EN is high in cycles n+2 .. n+K²+1, with WR_SEL equal to the tap index of the read issued in the previous cycle.
  - DONE is high in cycle n+K²+1 only.
  - BUSY is high in cycles n+1 .. n+K²+1.
- START while BUSY=1: ignored, with no queueing. A new START is accepted in the cycle after DONE, giving back-to-back loads with a one-cycle gap.
- Arithmetic: address additions wrap modulo 2^ADDR_W with no error flag. ROW_STRIDE=0 is legal and rereads the same row.
- Input changes while BUSY: K_SIZE, BASE_ADDR and ROW_STRIDE are ignored; the latched values are used.
- Reset mid-load: all outputs clear immediately, state becomes IDLE, no DONE is produced, and the partial load is abandoned.

Optional Feature:
- Macro: WINDOW_LOADER_ABORT_EN.
- With the macro defined:
  - Adds input ABORT (1 bit), sampled at each edge.
  - ABORT=1 while BUSY forces IDLE at the next edge.
  - The write for the read already in flight is suppressed.
  - DONE is not pulsed, and BUSY falls the cycle after ABORT is sampled.
  - ABORT in IDLE has no effect.
  - ABORT and START both high in IDLE: START wins.
- Without the macro: the ABORT port does not exist and loads always run to completion.

Decomposition:
- Shared package dcnn_pkg holds:
  - K-size encoding constants: K3=0, K5=1.
  - MAX_TAPS=25.
  - The state enum (IDLE, READ, LAST).
  - The SEL_W default.
- One natural sub-module: window_addr_gen. It holds the row/column counters and the row_base accumulator, and outputs address, tap index and a last-tap flag.
- The top level holds the FSM, the one-cycle write pipeline and the BUSY/DONE logic.

Test Plan:
- 3x3 load: K_SIZE=0, BASE=0x0100, STRIDE=0x0020, RAM[a]=a.
  - MEM_ADDR sequence: 0x100, 0x101, 0x102, 0x120, 0x121, 0x122, 0x140, 0x141, 0x142.
  - WR_SEL 0..8 with WR_DATA matching each address.
  - DONE in cycle n+10.
- 5x5 load: K_SIZE=1, BASE=0x0000, STRIDE=0x0040.
  - 25 writes, last write WR_SEL=24 with address 0x0104.
  - BUSY high for exactly 26 cycles.
- Address wrap: K_SIZE=0, BASE=0xFFFE, STRIDE=0x0001.
  - Addresses: 0xFFFE, 0xFFFF, 0x0000, 0xFFFF, 0x0000, 0x0001, 0x0000, 0x0001, 0x0002.
- START held high throughout a 3x3 load.
  - Exactly one load runs; the second load starts the cycle after DONE, with first MEM_RD at DONE+2.
- RST asserted at the fourth write of a 5x5 load.
  - All outputs go to 0 asynchronously and no DONE is produced.
  - A following START performs a full, correct load.
- WINDOW_LOADER_ABORT_EN build: ABORT pulsed during the sixth read of a 3x3 load.
  - At most 5 writes occur and DONE stays 0.
  - BUSY=0 the next cycle; a new START is accepted immediately.
